uart_tx_arbiter: RTL and testbench

- Shares one txuartlite transmitter between NREQ independent byte-stream sources, e.g. the hello-world banner, the pong score reporter and a debug dumper.
- Arbitration is round-robin with packet locking: a winner keeps the UART until it sends a byte flagged last, or until it stalls past a timeout.
- Each requester sees the same stb/busy handshake that txuartlite itself presents, so existing sources connect unchanged.
- Sits between the sources and the single txuartlite instance driving o_uart_tx.

---
 rtl/uart_arb_pkg.sv | 5 +
 rtl/rr_pick.sv | 26 ++
 rtl/uart_tx_arbiter.sv | 95 +++++++++
 tb/tb_uart_tx_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared types and constants for the UART transmit arbiter
package uart_arb_pkg;
   typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;
   localparam int UART_BYTE_W = 8;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first set bit of req scanning ptr, ptr+1, ... mod NREQ
//   req : request vector
//   ptr : index with highest priority
//   any : at least one request set
//   idx : chosen requester (0 when none)
module rr_pick #(
   parameter int NREQ = 4,
   parameter int GW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [GW-1:0]   ptr,
   output logic            any,
   output logic [GW-1:0]   idx
);
   logic [GW-1:0] j;
   always_comb begin
      any = |req;
      idx = '0;
      j   = '0;
      // Walk from the farthest offset back to ptr so the nearest set bit wins last.
      for (int i = NREQ - 1; i >= 0; i--) begin
         j = GW'((int'(ptr) + i) % NREQ);
         if (req[j]) idx = j;
      end
   end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locking share of one txuartlite between NREQ byte sources
//   i_clk, i_reset         : clock, synchronous active-high reset
//   i_stb, i_data, i_last  : per-requester byte handshake (byte k at i_data[8k+7:8k])
//   o_busy                 : per-requester busy, byte accepted on i_stb[k] && !o_busy[k]
//   o_tx_stb, o_tx_data    : strobe and byte toward txuartlite
//   i_tx_busy              : busy from txuartlite
//   o_grant_valid, o_grant : current lock holder
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int          NREQ         = 4,
   parameter logic [15:0] IDLE_TIMEOUT = 16'd1024,
   parameter int          GW           = $clog2(NREQ)
) (
   input  logic                        i_clk,
   input  logic                        i_reset,
   input  logic [NREQ-1:0]             i_stb,
   input  logic [NREQ*UART_BYTE_W-1:0] i_data,
   input  logic [NREQ-1:0]             i_last,
   output logic [NREQ-1:0]             o_busy,
   output logic                        o_tx_stb,
   output logic [UART_BYTE_W-1:0]      o_tx_data,
   input  logic                        i_tx_busy,
   output logic                        o_grant_valid,
   output logic [GW-1:0]               o_grant
);
   arb_state_t    state;
   logic [GW-1:0] rr_ptr, pick_idx, next_ptr;
   logic          pick_any, locked, sel_stb, sel_last, xfer;
   logic [15:0]   idle_cnt, idle_inc;

   rr_pick #(.NREQ(NREQ), .GW(GW)) u_pick (
      .req (i_stb),
      .ptr (rr_ptr),
      .any (pick_any),
      .idx (pick_idx)
   );

   assign locked = state == ARB_LOCKED;

   // Reset forces every requester busy at once so a byte cannot slip through
   // in the cycle the lock is being dropped.
   always_comb begin
      sel_stb   = 1'b0;
      sel_last  = 1'b0;
      o_tx_data = '0;
      o_busy    = '1;
      for (int k = 0; k < NREQ; k++) begin
         if (o_grant == GW'(k)) begin
            sel_stb   = i_stb[k];
            sel_last  = i_last[k];
            o_tx_data = i_data[k*UART_BYTE_W +: UART_BYTE_W];
         end
         o_busy[k] = !(locked && o_grant == GW'(k)) || i_tx_busy || i_reset;
      end
   end

   assign o_tx_stb = locked && sel_stb && !i_reset;
   assign xfer     = o_tx_stb && !i_tx_busy;
   assign next_ptr = (o_grant == GW'(NREQ - 1)) ? '0 : o_grant + GW'(1);
   assign idle_inc = &idle_cnt ? idle_cnt : idle_cnt + 16'd1;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state         <= ARB_IDLE;
         o_grant_valid <= 1'b0;
         o_grant       <= '0;
         rr_ptr        <= '0;
         idle_cnt      <= '0;
      end else if (state == ARB_IDLE) begin
         idle_cnt <= '0;
         if (pick_any) begin
            state         <= ARB_LOCKED;
            o_grant       <= pick_idx;
            o_grant_valid <= 1'b1;
         end
      end else if (xfer) begin
         idle_cnt <= '0;
         if (sel_last) begin
            state         <= ARB_IDLE;
            o_grant_valid <= 1'b0;
            rr_ptr        <= next_ptr;
         end
      end else if (!sel_stb) begin
         // Only an owner with nothing to offer counts as stalled; waiting on
         // the UART leaves the counter alone.
         idle_cnt <= idle_inc;
         if (IDLE_TIMEOUT != 16'd0 && idle_inc == IDLE_TIMEOUT) begin
            state         <= ARB_IDLE;
            o_grant_valid <= 1'b0;
            rr_ptr        <= next_ptr;
         end
      end
   end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench for uart_tx_arbiter against a txuartlite model
module tb_uart_tx_arbiter;
   localparam int NREQ = 4;
   logic            clk = 1'b0;
   logic            rst;
   logic [NREQ-1:0] i_stb, i_last, o_busy;
   logic [NREQ*8-1:0] i_data;
   logic            o_tx_stb, i_tx_busy, o_grant_valid;
   logic [7:0]      o_tx_data;
   logic [1:0]      o_grant;
   int   checks = 0, errors = 0, cyc = 0, tx_cnt = 0;
   logic hold = 1'b0, prev_valid = 1'b0;
   logic [8:0] src_q [NREQ][$];
   int   sb [$];
   int   xf_cyc [$], rise_cyc [$], fall_cyc [$];

   always #5 clk = ~clk;

   uart_tx_arbiter #(.NREQ(NREQ), .IDLE_TIMEOUT(16'd16)) dut (
      .i_clk         (clk),
      .i_reset       (rst),
      .i_stb         (i_stb),
      .i_data        (i_data),
      .i_last        (i_last),
      .o_busy        (o_busy),
      .o_tx_stb      (o_tx_stb),
      .o_tx_data     (o_tx_data),
      .i_tx_busy     (i_tx_busy),
      .o_grant_valid (o_grant_valid),
      .o_grant       (o_grant)
   );

   task automatic check(input string tag, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, want);
      end
   endtask

   task automatic drive();
      logic [8:0] v;
      for (int k = 0; k < NREQ; k++) begin
         v = src_q[k].size() > 0 ? src_q[k][0] : 9'h0;
         i_stb[k]          = src_q[k].size() > 0;
         i_last[k]         = v[8];
         i_data[k*8 +: 8]  = v[7:0];
      end
      i_tx_busy = hold || tx_cnt != 0;
   endtask

   task automatic src_push(input int k, input int d, input bit l);
      src_q[k].push_back({l, 8'(d)});
   endtask

   task automatic sb_push(input int k, input int d);
      sb.push_back(k * 256 + d);
   endtask

   task automatic send(input int k, input int d, input bit l);
      src_push(k, d, l);
      sb_push(k, d);
   endtask

   task automatic clear_log();
      xf_cyc.delete();
      rise_cyc.delete();
      fall_cyc.delete();
   endtask

   function automatic bit pending();
      bit p = sb.size() != 0 || o_grant_valid || tx_cnt != 0;
      for (int k = 0; k < NREQ; k++) if (src_q[k].size() != 0) p = 1'b1;
      return p;
   endfunction

   task automatic step();
      logic [NREQ-1:0] acc;
      logic tx_acc;
      int nz, e;
      @(negedge clk);
      cyc++;
      acc    = i_stb & ~o_busy;
      tx_acc = o_tx_stb && !i_tx_busy;
      nz = 0;
      for (int k = 0; k < NREQ; k++) if (!o_busy[k]) nz++;
      check("busy_onehot", int'(nz <= 1), 1);
      if (o_grant_valid && !prev_valid) rise_cyc.push_back(cyc);
      if (!o_grant_valid && prev_valid) fall_cyc.push_back(cyc);
      prev_valid = o_grant_valid;
      if (tx_acc) begin
         xf_cyc.push_back(cyc);
         check("sb_nonempty", int'(sb.size() != 0), 1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("tx_grant", o_grant, e / 256);
            check("tx_data", o_tx_data, e % 256);
         end
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < NREQ; k++) if (acc[k]) void'(src_q[k].pop_front());
      tx_cnt = tx_acc ? 10 : (tx_cnt > 0 ? tx_cnt - 1 : 0);
      drive();
   endtask

   task automatic run_until_idle(input int budget);
      int n = 0;
      do begin
         step();
         n++;
      end while (pending() && n < budget);
      check("drained", int'(pending()), 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      int c0, rel, n, ok;
      rst = 1'b1;
      i_stb = '0; i_last = '0; i_data = '0; i_tx_busy = 1'b0;
      step();
      step();
      check("rst_valid", o_grant_valid, 0);
      check("rst_grant", o_grant, 0);
      check("rst_tx_stb", o_tx_stb, 0);
      check("rst_busy", o_busy, 15);
      check("rst_ptr", dut.rr_ptr, 0);
      rst = 1'b0;

      // single source "Hi\r\n" from requester 2
      clear_log();
      send(2, 'h48, 0); send(2, 'h69, 0); send(2, 'h0D, 0); send(2, 'h0A, 1);
      drive();
      c0 = cyc;
      run_until_idle(200);
      check("t1_bytes", xf_cyc.size(), 4);
      if (xf_cyc.size() == 4 && rise_cyc.size() >= 1 && fall_cyc.size() >= 1) begin
         check("t1_grant_lat", rise_cyc[0], c0 + 2);
         check("t1_first_byte", xf_cyc[0], c0 + 2);
         check("t1_drop", fall_cyc[0], xf_cyc[3] + 1);
      end
      check("t1_ptr", dut.rr_ptr, 3);

      // contention from reset: 0,1,3 with one idle cycle between packets
      do_reset();
      clear_log();
      send(0, 'h10, 0); send(0, 'h11, 1);
      send(1, 'h20, 0); send(1, 'h21, 1);
      send(3, 'h30, 0); send(3, 'h31, 1);
      drive();
      run_until_idle(300);
      check("t2_grants", rise_cyc.size(), 3);
      if (rise_cyc.size() == 3 && fall_cyc.size() >= 2) begin
         check("t2_gap01", rise_cyc[1] - fall_cyc[0], 1);
         check("t2_gap13", rise_cyc[2] - fall_cyc[1], 1);
      end
      check("t2_ptr", dut.rr_ptr, 0);

      // wrap fairness: move ptr to 3, then 3 and 0 pending
      clear_log();
      send(2, 'hC0, 1);
      drive();
      run_until_idle(100);
      check("t3_pre_ptr", dut.rr_ptr, 3);
      send(3, 'hD0, 0); send(3, 'hD1, 1); send(0, 'hE0, 1);
      drive();
      run_until_idle(200);
      check("t3_ptr", dut.rr_ptr, 1);

      // timeout: requester 1 stalls after one non-last byte, requester 2 waiting
      clear_log();
      send(1, 'hA5, 0);
      send(2, 'h31, 0); send(2, 'h32, 1);
      drive();
      run_until_idle(300);
      if (xf_cyc.size() >= 1 && fall_cyc.size() >= 1 && rise_cyc.size() >= 2) begin
         check("t4_release", fall_cyc[0] - xf_cyc[0], 17);
         check("t4_regrant", rise_cyc[1] - fall_cyc[0], 1);
      end
      check("t4_ptr", dut.rr_ptr, 3);

      // UART held busy for 2000 cycles: no timeout, byte waits
      clear_log();
      hold = 1'b1;
      send(0, 'h77, 1);
      drive();
      ok = 1;
      repeat (2000) begin
         step();
         if (!o_busy[0]) ok = 0;
      end
      check("t5_busy_held", ok, 1);
      check("t5_locked", o_grant_valid, 1);
      check("t5_grant", o_grant, 0);
      check("t5_no_xfer", xf_cyc.size(), 0);
      hold = 1'b0;
      drive();
      rel = cyc;
      run_until_idle(100);
      if (xf_cyc.size() >= 1) check("t5_accept_cyc", xf_cyc[0], rel + 1);
      check("t5_ptr", dut.rr_ptr, 1);

      // reset during second byte of a 4-byte packet from requester 2
      clear_log();
      send(2, 'h41, 0);
      src_push(2, 'h42, 0); src_push(2, 'h43, 0); src_push(2, 'h44, 1);
      drive();
      n = 0;
      while (xf_cyc.size() == 0 && n < 50) begin
         step();
         n++;
      end
      check("t6_first", xf_cyc.size(), 1);
      src_push(0, 'h50, 1);
      src_push(3, 'h60, 1);
      drive();
      repeat (3) step();
      check("t6_mid_grant", o_grant, 2);
      check("t6_mid_valid", o_grant_valid, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("t6_valid", o_grant_valid, 0);
      check("t6_tx_stb", o_tx_stb, 0);
      check("t6_busy", o_busy, 15);
      check("t6_ptr_rst", dut.rr_ptr, 0);
      sb_push(0, 'h50);
      sb_push(2, 'h42); sb_push(2, 'h43); sb_push(2, 'h44);
      sb_push(3, 'h60);
      run_until_idle(300);
      check("t6_ptr", dut.rr_ptr, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
